gray_step_controller: RTL
=========================

GRAY_STEP_CONTROLLER -- requirements
Module: gray_step_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of step count.
REQ-002 SHALL have parameter DIV_W, default 8: width of rate divider.
REQ-003 SHALL have parameter POS_W, default 16: width of position counter (used only under GRAY_STEP_POS_EN).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  move request, sampled only in IDLE.
REQ-007 SHALL have port dir  input  1  direction: 1 = forward, 0 = reverse; latched on start.
REQ-008 SHALL have port steps  input  CNT_W  number of gray steps to issue; latched on start.
REQ-009 SHALL have port div  input  DIV_W  step period minus one, in clocks; latched on start.
REQ-010 SHALL have port abort  input  1  terminate the current move.
REQ-011 SHALL have port phase  output  2  registered 2-bit gray output.
REQ-012 SHALL have port busy  output  1  high while in RUN.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port aborted  output  1  high together with done when the move was aborted.
REQ-015 SHALL have port remaining  output  CNT_W  steps still to issue.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 SHALL, in IDLE with start=1 and steps!=0, latch dir, steps and div, clear the prescaler, and enter RUN on that edge.
REQ-018 SHALL, in IDLE with start=1 and steps=0, enter DONE directly, leaving phase unchanged.
REQ-019 SHALL, in RUN, increment the prescaler each clock; when prescaler==div_q, the prescaler clears, phase advances one gray step, and remaining decrements.
REQ-020 SHALL use forward sequence 00->01->11->10->00 and reverse sequence 00->10->11->01->00, with wrap-around in both directions.
REQ-021 SHALL make the first phase change at accept edge + (div+1) clocks; N steps SHALL complete at accept edge + N*(div+1).
REQ-022 SHALL move from RUN to DONE on the edge that issues the step taking remaining from 1 to 0.
REQ-023 SHALL assert done for exactly one cycle while in DONE, then return to IDLE.
REQ-024 SHALL give abort in RUN priority over a coincident step tick: no phase change, remaining frozen, next state DONE, aborted=1 with done.
REQ-025 SHALL ignore abort outside RUN, and ignore start in RUN and DONE.
REQ-026 SHALL hold phase across moves; phase is never re-initialised except by reset.
REQ-027 SHALL make all outputs registered, with no combinational input-to-output paths.

Reset
REQ-028 SHALL, on rst=1, asynchronously force state=IDLE, phase=00, busy=0, done=0, aborted=0, remaining=0, prescaler=0 (and position=0 when enabled).
REQ-029 SHALL, on reset mid-move, discard the move with no done pulse; first active edge after release is in IDLE.

Configuration
REQ-030 SHALL, when macro GRAY_STEP_POS_EN is defined, add output position (POS_W, two's complement): +1 per forward step and -1 per reverse step, wrapping modulo 2^POS_W, unchanged by abort.
REQ-031 SHALL, without GRAY_STEP_POS_EN, have no position port or counter logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover: reset, then start, dir=1, steps=4, div=0 -> phase 01,11,10,00 on 4 consecutive edges; done pulse 1 cycle; busy high 4 cycles.
REQ-033 SHALL cover: dir=0, steps=3, div=2 from phase 00 -> phase 10,11,01, one change every 3 clocks; remaining 3->2->1->0.
REQ-034 SHALL cover: start with steps=0 -> done=1 for one cycle, aborted=0, phase unchanged, busy never high.
REQ-035 SHALL cover: steps=10, div=1, abort coincident with 3rd tick -> phase shows 2 steps only, remaining=8, done=1 and aborted=1 together.
REQ-036 SHALL cover: rst asserted mid-move -> immediate phase=00, busy=0; no done; new start after release behaves as REQ-032.
REQ-037 SHALL cover, with GRAY_STEP_POS_EN: +5 forward then 7 reverse -> position=-2 (0xFFFE at POS_W=16).

Source files
------------

// File: rtl/gray_step_controller.sv
// Gray-code stepper: issues `steps` quadrature phase steps, one every div+1 clocks.
// Optional signed position counter is enabled by defining GRAY_STEP_POS_EN.
module gray_step_controller #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 8,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] div,
  input  logic             abort,
  output logic [1:0]       phase,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] remaining,
`ifdef GRAY_STEP_POS_EN
  output logic [POS_W-1:0] position,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       phase_n;
  logic             busy_n, done_n, aborted_n;
  logic [CNT_W-1:0] remaining_n;
  logic [DIV_W-1:0] presc, presc_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic             dir_q, dir_n;

`ifdef GRAY_STEP_POS_EN
  logic [POS_W-1:0] pos_n;
`else
  // Keeps POS_W referenced in the build without the position counter.
  logic [POS_W-1:0] unused_pos;
  assign unused_pos = '0;
`endif

  assign state_dbg = state;

  // Forward: 00->01->11->10, reverse walks the same ring backwards.
  function automatic logic [1:0] gray_step(input logic [1:0] p, input logic fwd);
    if (fwd) return {p[0], ~p[1]};
    else     return {~p[0], p[1]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      remaining <= '0;
      presc     <= '0;
      div_q     <= '0;
      dir_q     <= 1'b0;
`ifdef GRAY_STEP_POS_EN
      position  <= '0;
`endif
    end else begin
      phase     <= phase_n;
      busy      <= busy_n;
      done      <= done_n;
      aborted   <= aborted_n;
      remaining <= remaining_n;
      presc     <= presc_n;
      div_q     <= div_n;
      dir_q     <= dir_n;
`ifdef GRAY_STEP_POS_EN
      position  <= pos_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    busy_n      = busy;
    done_n      = 1'b0;
    aborted_n   = 1'b0;
    remaining_n = remaining;
    presc_n     = presc;
    div_n       = div_q;
    dir_n       = dir_q;
`ifdef GRAY_STEP_POS_EN
    pos_n       = position;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (steps != '0) begin
            state_n     = RUN;
            busy_n      = 1'b1;
            dir_n       = dir;
            div_n       = div;
            remaining_n = steps;
            presc_n     = '0;
          end else begin
            state_n     = DONE;
            done_n      = 1'b1;
            remaining_n = '0;
          end
        end
      end
      RUN: begin
        // Abort wins over a coincident tick: nothing moves on that edge.
        if (abort) begin
          state_n   = DONE;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          aborted_n = 1'b1;
          presc_n   = '0;
        end else if (presc == div_q) begin
          presc_n     = '0;
          phase_n     = gray_step(phase, dir_q);
          remaining_n = remaining - CNT_W'(1);
`ifdef GRAY_STEP_POS_EN
          pos_n       = dir_q ? position + POS_W'(1) : position - POS_W'(1);
`endif
          if (remaining == CNT_W'(1)) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end else begin
          presc_n = presc + DIV_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
